// File: rtl/sw_debounce.sv
// Slide-switch conditioner: 2-flop synchroniser, per-bit stability filter, rise/fall pulses.
// Define SW_DEBOUNCE_EVT_LATCH_EN to add sticky per-bit event flags (evt_pend) cleared by evt_clr.
module sw_debounce #(
  parameter int unsigned  WIDTH     = 8,
  parameter int unsigned  DB_CYCLES = 4,
  localparam int unsigned CNT_W     = $clog2(DB_CYCLES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw,
`ifdef SW_DEBOUNCE_EVT_LATCH_EN
  input  logic             evt_clr,
  output logic [WIDTH-1:0] evt_pend,
`endif
  output logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed,
  output logic             nz
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DB_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] sw_q, sw_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             changed_q, changed_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] flip;

  // Count consecutive cycles the synchronised level disagrees with the stable level; any
  // agreement (bounce back) restarts the count, and a completed count flips the bit.
  always_comb begin
    flip = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != sw_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          flip[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    sw_d      = sw_q ^ flip;
    rise_d    = flip & sync2_q;
    fall_d    = flip & ~sync2_q;
    changed_d = |flip;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      sw_q      <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      sw_q      <= sw_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sw      = sw_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign changed = changed_q;
  assign nz      = |sw_q;

`ifdef SW_DEBOUNCE_EVT_LATCH_EN
  logic [WIDTH-1:0] evt_pend_q, evt_pend_d;

  // A new event in the clearing cycle survives the clear.
  always_comb begin
    evt_pend_d = (evt_pend_q & ~{WIDTH{evt_clr}}) | rise_q | fall_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_pend_q <= '0;
    end else begin
      evt_pend_q <= evt_pend_d;
    end
  end

  assign evt_pend = evt_pend_q;
`endif

  a_rise_fall_excl: assert property (@(posedge clk) disable iff (!rst_n)
    (rise_q & fall_q) == '0);

  a_changed_or: assert property (@(posedge clk) disable iff (!rst_n)
    changed_q == |(rise_q | fall_q));

  for (genvar g = 0; g < WIDTH; g++) begin : g_cnt_chk
    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
      cnt_q[g] <= CntMax);
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: constant vector table, directed corner sequences, and random
// stimulus checked every cycle against a window-based reference model.
module tb_sw_debounce;
  localparam int W  = 8;
  localparam int DB = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] raw;
  logic         evt_clr;
  logic [W-1:0] sw, rise, fall;
  logic         changed, nz;
`ifdef SW_DEBOUNCE_EVT_LATCH_EN
  logic [W-1:0] evt_pend;
`endif

  sw_debounce #(.WIDTH(W), .DB_CYCLES(DB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw     (raw),
`ifdef SW_DEBOUNCE_EVT_LATCH_EN
    .evt_clr (evt_clr),
    .evt_pend(evt_pend),
`endif
    .sw      (sw),
    .rise    (rise),
    .fall    (fall),
    .changed (changed),
    .nz      (nz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a bit flips at edge n when every synchronised sample it saw over the
  // last DB edges disagreed with the stable level and none of those edges predates the
  // previous flip. Sample seen at edge n is raw captured at edge n-2 (zero before that).
  logic [W-1:0] hist[$];
  int           n;
  int           last_flip[W];
  logic [W-1:0] m_sw, m_rise, m_fall, m_pend;
  logic         m_ch;

  function automatic logic [W-1:0] seen_at(input int m);
    if (m < 2) return '0;
    return hist[m-2];
  endfunction

  task automatic model_reset();
    hist.delete();
    n      = 0;
    m_sw   = '0;
    m_rise = '0;
    m_fall = '0;
    m_pend = '0;
    m_ch   = 1'b0;
    for (int i = 0; i < W; i++) last_flip[i] = -1000;
  endtask

  task automatic model_edge(input logic [W-1:0] r, input logic clr);
    logic [W-1:0] flip, prev_ev, s;
    bit           ok;
    prev_ev = m_rise | m_fall;
    hist.push_back(r);
    flip = '0;
    for (int i = 0; i < W; i++) begin
      if ((n - last_flip[i] >= DB) && (n - DB + 1 >= 0)) begin
        ok = 1'b1;
        for (int m = n - DB + 1; m <= n; m++) begin
          s = seen_at(m);
          if (s[i] == m_sw[i]) ok = 1'b0;
        end
        if (ok) begin
          flip[i]      = 1'b1;
          last_flip[i] = n;
        end
      end
    end
    m_rise = flip & ~m_sw;
    m_fall = flip & m_sw;
    m_sw   = m_sw ^ flip;
    m_ch   = |flip;
    m_pend = (m_pend & ~{W{clr}}) | prev_ev;
    n++;
  endtask

  // Called at a negedge; applies r, advances one rising edge, compares against the model.
  task automatic tick(input logic [W-1:0] r);
    raw = r;
    @(posedge clk);
    model_edge(r, evt_clr);
    #1;
    chk("model_sw", sw, m_sw);
    chk("model_rise", rise, m_rise);
    chk("model_fall", fall, m_fall);
    chk("model_changed", {7'd0, changed}, {7'd0, m_ch});
    chk("model_nz", {7'd0, nz}, {7'd0, |m_sw});
`ifdef SW_DEBOUNCE_EVT_LATCH_EN
    chk("model_evt_pend", evt_pend, m_pend);
`endif
    @(negedge clk);
  endtask

  typedef struct {
    logic [W-1:0] raw;
    logic [W-1:0] sw;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         ch;
  } vec_t;

  vec_t         tbl[25];
  logic [W-1:0] r, tg;
  int           rise_idx, fall_idx, rise_cnt, fall_cnt;

  initial begin
    rst_n   = 1'b0;
    raw     = '0;
    evt_clr = 1'b0;
    model_reset();

    // Single-bit rise/fall, then all-at-once A5 rise/fall; starts from a settled zero state.
    tbl[0]  = '{8'h01, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[1]  = '{8'h01, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[2]  = '{8'h01, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[3]  = '{8'h01, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[4]  = '{8'h01, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[5]  = '{8'h01, 8'h01, 8'h01, 8'h00, 1'b1};
    tbl[6]  = '{8'h00, 8'h01, 8'h00, 8'h00, 1'b0};
    tbl[7]  = '{8'h00, 8'h01, 8'h00, 8'h00, 1'b0};
    tbl[8]  = '{8'h00, 8'h01, 8'h00, 8'h00, 1'b0};
    tbl[9]  = '{8'h00, 8'h01, 8'h00, 8'h00, 1'b0};
    tbl[10] = '{8'h00, 8'h01, 8'h00, 8'h00, 1'b0};
    tbl[11] = '{8'h00, 8'h00, 8'h00, 8'h01, 1'b1};
    tbl[12] = '{8'hA5, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[13] = '{8'hA5, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[14] = '{8'hA5, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[15] = '{8'hA5, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[16] = '{8'hA5, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[17] = '{8'hA5, 8'hA5, 8'hA5, 8'h00, 1'b1};
    tbl[18] = '{8'h00, 8'hA5, 8'h00, 8'h00, 1'b0};
    tbl[19] = '{8'h00, 8'hA5, 8'h00, 8'h00, 1'b0};
    tbl[20] = '{8'h00, 8'hA5, 8'h00, 8'h00, 1'b0};
    tbl[21] = '{8'h00, 8'hA5, 8'h00, 8'h00, 1'b0};
    tbl[22] = '{8'h00, 8'hA5, 8'h00, 8'h00, 1'b0};
    tbl[23] = '{8'h00, 8'h00, 8'h00, 8'hA5, 1'b1};
    tbl[24] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0};

    repeat (3) @(negedge clk);
    chk("in_reset_sw", sw, 8'h00);
    chk("in_reset_pulses", rise | fall, 8'h00);
    chk("in_reset_flags", {6'd0, changed, nz}, 8'h00);
    rst_n = 1'b1;

    for (int k = 0; k < 20; k++) begin
      tick(8'h00);
      chk("idle_sw", sw, 8'h00);
      chk("idle_flags", {6'd0, changed, nz}, 8'h00);
    end

    for (int k = 0; k < 25; k++) begin
      tick(tbl[k].raw);
      chk("tbl_sw", sw, tbl[k].sw);
      chk("tbl_rise", rise, tbl[k].rise);
      chk("tbl_fall", fall, tbl[k].fall);
      chk("tbl_changed", {7'd0, changed}, {7'd0, tbl[k].ch});
      chk("tbl_nz", {7'd0, nz}, {7'd0, tbl[k].sw != 8'h00});
    end

    // Bit 3 chatters every cycle: must never pass the filter.
    for (int k = 0; k < 16; k++) begin
      tick((k < 10 && (k % 2 == 0)) ? 8'h08 : 8'h00);
      chk("chatter_sw", sw, 8'h00);
      chk("chatter_pulses", rise | fall, 8'h00);
    end

    // Bit 7 high for DB-1 cycles is rejected.
    for (int k = 0; k < 11; k++) begin
      tick(k < 3 ? 8'h80 : 8'h00);
      chk("short_glitch_sw", sw, 8'h00);
    end

    // Bit 7 high for exactly DB cycles passes, then falls back.
    rise_idx = -1;
    fall_idx = -1;
    rise_cnt = 0;
    fall_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      tick(k < 4 ? 8'h80 : 8'h00);
      if (rise[7]) begin rise_cnt++; rise_idx = k; end
      if (fall[7]) begin fall_cnt++; fall_idx = k; end
    end
    chk("b7_rise_count", 8'(rise_cnt), 8'd1);
    chk("b7_fall_count", 8'(fall_cnt), 8'd1);
    chk("b7_rise_edge", 8'(rise_idx), 8'd5);
    chk("b7_fall_edge", 8'(fall_idx), 8'd9);

    // Establish a nonzero stable value, start a count, then reset asynchronously.
    for (int k = 0; k < 8; k++) tick(8'h0F);
    chk("pre_reset_sw", sw, 8'h0F);
    for (int k = 0; k < 3; k++) tick(8'hFF);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_sw", sw, 8'h00);
    chk("async_reset_pulses", rise | fall, 8'h00);
    chk("async_reset_flags", {6'd0, changed, nz}, 8'h00);
`ifdef SW_DEBOUNCE_EVT_LATCH_EN
    chk("async_reset_pend", evt_pend, 8'h00);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 6; k++) begin
      tick(8'hFF);
      chk("post_reset_sw", sw, (k == 5) ? 8'hFF : 8'h00);
      chk("post_reset_rise", rise, (k == 5) ? 8'hFF : 8'h00);
    end
    for (int k = 0; k < 3; k++) tick(8'hFF);
`ifdef SW_DEBOUNCE_EVT_LATCH_EN
    chk("pend_held", evt_pend, 8'hFF);
    evt_clr = 1'b1;
    tick(8'hFF);
    evt_clr = 1'b0;
    chk("pend_cleared", evt_pend, 8'h00);
    tick(8'hFF);
    chk("pend_stays_clear", evt_pend, 8'h00);
`endif

    // Random: sparse per-bit toggles so some levels settle and others bounce.
    r = 8'hFF;
    for (int k = 0; k < 3000; k++) begin
      tg = '0;
      if ($urandom_range(0, 2) == 0) begin
        for (int b = 0; b < W; b++) tg[b] = ($urandom_range(0, 4) == 0);
      end
      r       = r ^ tg;
      evt_clr = ($urandom_range(0, 7) == 0);
      tick(r);
    end
    evt_clr = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
- Input-conditioning stage directly upstream of the 8-to-3 priority encoder and seven-segment encoder on the board top.
- Takes raw, asynchronous slide-switch levels and synchronises each bit with a 2-flop chain.
- Filters each bit independently with a stability counter.
- Presents clean, registered switch levels plus per-bit rise/fall event pulses and a nonzero flag. The encoders consume these instead of raw pins.

Parameters:
- WIDTH, 8, number of switch bits filtered.
- DB_CYCLES, 4, consecutive cycles a synchronised bit must differ from the stable value before the stable value flips; legal range >= 2 (board build uses 2000000 at 50 MHz).
- CNT_W, $clog2(DB_CYCLES), per-bit counter width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset; assertion is asynchronous, deassertion is synchronous to clk.
- raw  input  WIDTH  unsynchronised switch levels.
- sw  output  WIDTH  debounced stable levels; feeds encoder x.
- rise  output  WIDTH  one-cycle pulse per bit when sw[i] goes 0->1.
- fall  output  WIDTH  one-cycle pulse per bit when sw[i] goes 1->0.
- changed  output  1  OR of rise|fall, registered with them.
- nz  output  1  1 iff sw != 0; combinational from sw (drives the top's flag).

Behaviour:
- Reset (rst_n=0, async): sync1, sync2, sw, all counters, rise, fall and changed are all 0; nz is therefore 0.
- Synchroniser: sync1<=raw, sync2<=sync1 every edge; nothing else samples raw.
- Per bit i, each edge:
  - If sync2[i]==sw[i]: cnt[i]<=0, no event.
  - Else if cnt[i]==DB_CYCLES-1: sw[i]<=sync2[i], cnt[i]<=0, and rise[i] or fall[i] <=1 per direction.
  - Else cnt[i]<=cnt[i]+1.
- rise and fall are cleared to 0 on every edge where no flip occurs, so each pulse lasts exactly one cycle.
- Latency: raw change first sampled at edge E0 -> sw and the pulse update at edge E0+DB_CYCLES+1; fixed, no jitter beyond the sampling edge.
- Glitch rejection: any bounce returning sync2[i] to sw[i] before the count completes resets cnt[i]; the count restarts from 0 on the next difference. A glitch lasting <= DB_CYCLES-1 cycles never reaches sw.
- Bits are fully independent; simultaneous flips on several bits in one cycle give multiple rise/fall bits set together with a single changed=1.
- Counter never wraps: it is held at or reset to 0 on reaching DB_CYCLES-1.
- Reset mid-count: count is discarded. If raw is held at 1 through reset release, sw rises DB_CYCLES+1 edges after the first post-reset sampling edge, with a rise pulse.
- No combinational path from raw to any output.

Optional Feature:
- Macro: SW_DEBOUNCE_EVT_LATCH_EN.
- Defined: adds input evt_clr (1) and output evt_pend (WIDTH).
  - evt_pend[i] is set by rise[i]|fall[i] and cleared by evt_clr. A set in the same cycle as evt_clr wins.
  - evt_pend resets to 0.
- Undefined: ports absent; only pulse outputs exist; behaviour otherwise identical.

Test Plan:
- Reset, raw=8'h00, DB_CYCLES=4 -> sw=0, nz=0, rise=fall=0, changed=0 for 20 cycles.
- raw 0->8'h01 held (first sampled E0) -> sw=8'h01 at E5; rise=8'h01 and changed=1 for exactly one cycle at E5; nz=1 from E5.
- raw bit3 toggles 1,0,1,0 every cycle for 10 cycles then settles 0 -> sw[3] stays 0 throughout; no pulses.
- raw bit7 high for exactly 3 cycles then low -> sw unchanged; high for 4 cycles -> sw[7]=1 then returns to 0 after another DB_CYCLES+1 edges with fall[7] pulse.
- raw 8'h00->8'hA5 in one cycle -> sw=8'hA5 at E5; rise=8'hA5 in a single cycle; then raw->8'h00 gives fall=8'hA5 one cycle.
- rst_n pulsed low mid-count with raw=8'hFF -> outputs 0 immediately (async); after release sw=8'hFF DB_CYCLES+1 edges after the first sampling edge. With SW_DEBOUNCE_EVT_LATCH_EN: evt_pend=8'hFF holds until evt_clr, then 0.
